// File: rtl/d_sramlike_axi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// d_sramlike_axi_bridge_pkg
// Shared definitions for the data-side SRAM-like to AXI3 bridge and for the
// D-cache that drives it: FSM state encodings, SRAM-like size codes, the
// constant AXI burst fields the top wrapper drives, and the size+offset to
// byte-strobe function (also used for the D-cache write mask).
// ---------------------------------------------------------------------------
package d_sramlike_axi_bridge_pkg;

    // Bridge FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_AR  = 3'd1;
    localparam logic [2:0] ST_RD_R   = 3'd2;
    localparam logic [2:0] ST_WR_REQ = 3'd3;
    localparam logic [2:0] ST_WR_B   = 3'd4;

    // SRAM-like transfer sizes (code 3 is handled as a word)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Constant AXI fields driven by the top-level wrapper
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    // Byte-lane strobe for a transfer of the given size at the given
    // byte offset within the 32-bit word.
    function automatic logic [3:0] calc_wstrb(input logic [1:0] size,
                                              input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << offset;
            SIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sramlike_wstrb_gen.sv
// ---------------------------------------------------------------------------
// sramlike_wstrb_gen
// Combinational byte-strobe generator for SRAM-like transfers.
// Ports:
//   size   in  2  transfer size (0 byte, 1 half, 2/3 word)
//   offset in  2  byte address bits [1:0]
//   wstrb  out 4  AXI write strobe
// ---------------------------------------------------------------------------
module sramlike_wstrb_gen
    import d_sramlike_axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] wstrb
);

    assign wstrb = calc_wstrb(size, offset);

endmodule

// File: rtl/d_sramlike_axi_bridge.sv
// ---------------------------------------------------------------------------
// d_sramlike_axi_bridge
// Responder for the D-cache SRAM-like bus. Each accepted transfer becomes one
// single-beat AXI3 transaction (AR/R for reads, AW/W/B for writes); only one
// transaction is outstanding at a time.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   data_req/wr/size/addr/wdata    SRAM-like request side (from D-cache)
//   data_rdata/addr_ok/data_ok     SRAM-like response side
//   ar*, r*                        AXI read address / read data channels
//   aw*, w*, b*                    AXI write address / data / response
// len/burst/lock/cache/prot are tied off by the top-level AXI wrapper.
// ---------------------------------------------------------------------------
module d_sramlike_axi_bridge
    import d_sramlike_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // SRAM-like side
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    // AXI read address
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    // AXI read data
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    // AXI write data
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI write response
    input  logic              bvalid,
    output logic              bready
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              aw_done;
    logic              w_done;

    logic [3:0]        req_wstrb;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              aw_fin;
    logic              w_fin;
    logic              rd_resp;
    logic              wr_resp;

    sramlike_wstrb_gen u_wstrb_gen (
        .size   (data_size),
        .offset (data_addr[1:0]),
        .wstrb  (req_wstrb)
    );

    assign ar_hs  = arvalid_q && arready;
    assign aw_hs  = awvalid_q && awready;
    assign w_hs   = wvalid_q && wready;
    // A channel counts as finished if it completed earlier or completes now,
    // so AW and W may finish in either order or together.
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;

    assign rd_resp = (state == ST_RD_R);
    assign wr_resp = (state == ST_WR_B);

    // SRAM-like side: accept only in IDLE, complete on the AXI response beat.
    assign data_addr_ok = (state == ST_IDLE) && data_req && !rst;
    assign data_data_ok = (rd_resp && rvalid) || (wr_resp && bvalid);
    assign data_rdata   = (rd_resp && rvalid) ? rdata : 32'd0;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = rd_resp;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;

    assign bready  = wr_resp;

    // Transfer direction is carried by the state itself, so no separate
    // write flag is kept after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_req) begin
                        addr_q  <= data_addr;
                        size_q  <= data_size;
                        wdata_q <= data_wdata;
                        wstrb_q <= req_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (data_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RD_AR;
                        end
                    end
                end
                ST_RD_AR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    // bresp is not examined: error responses complete normally
                    if (bvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_sramlike_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_d_sramlike_axi_bridge
// Directed and randomized bench for d_sramlike_axi_bridge. A transaction-level
// reference model (pending channel flags + latched request) predicts every
// output each cycle; directed steps add explicit value checks.
// ---------------------------------------------------------------------------
module tb_d_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_sramlike_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awid         (awid),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wid          (wid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    // ---------------- reference model ----------------
    bit          m_busy, m_wr, m_ar, m_aw, m_w, m_resp;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [3:0]  m_strb;

    // Strobe from byte count: (2^bytes - 1) shifted to the size-aligned offset.
    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        int off;
        bytes = (size == 2'd3) ? 4 : (1 << size);
        off   = (int'(addr[1:0]) / bytes) * bytes;
        return 4'(((1 << bytes) - 1) << off);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_ar = 0; m_aw = 0; m_w = 0; m_resp = 0;
        m_addr = 32'd0; m_wdata = 32'd0; m_size = 2'd0; m_strb = 4'd0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (data_req) begin
                m_busy  = 1;
                m_wr    = data_wr;
                m_addr  = data_addr;
                m_size  = data_size;
                m_wdata = data_wdata;
                m_strb  = ref_strb(data_size, data_addr);
                m_resp  = 0;
                if (data_wr) begin
                    m_aw = 1;
                    m_w  = 1;
                end else begin
                    m_ar = 1;
                end
            end
        end else if (m_resp) begin
            if (m_wr ? bvalid : rvalid) begin
                m_busy = 0;
                m_resp = 0;
            end
        end else if (m_wr) begin
            if (awready) m_aw = 0;
            if (wready)  m_w  = 0;
            if (!m_aw && !m_w) m_resp = 1;
        end else if (arready) begin
            m_ar   = 0;
            m_resp = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Settle, then compare every output with the model's prediction.
    task automatic look();
        logic rsp_rd;
        logic rsp_wr;
        #1;
        rsp_rd = m_resp && !m_wr;
        rsp_wr = m_resp && m_wr;
        check("addr_ok", 32'(data_addr_ok), 32'(!rst && !m_busy && data_req));
        check("data_ok", 32'(data_data_ok), 32'((rsp_rd && rvalid) || (rsp_wr && bvalid)));
        check("data_rdata", data_rdata, (rsp_rd && rvalid) ? rdata : 32'd0);
        check("arvalid", 32'(arvalid), 32'(m_ar));
        check("awvalid", 32'(awvalid), 32'(m_aw));
        check("wvalid", 32'(wvalid), 32'(m_w));
        check("rready", 32'(rready), 32'(rsp_rd));
        check("bready", 32'(bready), 32'(rsp_wr));
        check("araddr", araddr, m_addr);
        check("awaddr", awaddr, m_addr);
        check("arsize", 32'(arsize), 32'({1'b0, m_size}));
        check("awsize", 32'(awsize), 32'({1'b0, m_size}));
        check("wdata", wdata, m_wdata);
        check("wstrb", 32'(wstrb), 32'(m_strb));
        check("ids", {20'd0, arid, awid, wid}, {20'd0, 12'h111});
        check("wlast", 32'(wlast), 32'd1);
    endtask

    task automatic adv();
        if (!rst) model_step();
        @(posedge clk);
        #1;
        if (rst) model_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            look();
            adv();
        end
    endtask

    task automatic quiet();
        data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 32'd0;
    endtask

    task automatic request(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
        data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    endtask

    initial begin
        logic [31:0] half_addr [2];
        logic [3:0]  half_strb [2];
        half_addr[0] = 32'h0000_0010; half_strb[0] = 4'b0011;
        half_addr[1] = 32'h0000_0012; half_strb[1] = 4'b1100;

        // Reset, including a request held during reset
        rst = 1;
        quiet();
        model_reset();
        #1;
        look();
        adv();
        data_req = 1;
        look();
        check("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        adv();
        data_req = 0;
        rst = 0;
        run(1);

        // Read, zero-wait slave
        request(0, 2'd2, 32'h1FC0_0004, 32'd0);
        arready = 1;
        look();
        check("rd_addr_ok", 32'(data_addr_ok), 32'd1);
        adv();
        data_req = 0;
        look();
        check("rd_araddr", araddr, 32'h1FC0_0004);
        check("rd_arsize", 32'(arsize), 32'd2);
        adv();
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        look();
        check("rd_data_ok", 32'(data_data_ok), 32'd1);
        check("rd_rdata", data_rdata, 32'hDEAD_BEEF);
        adv();
        quiet();
        look();
        check("rd_rdata_idle", data_rdata, 32'd0);
        adv();

        // Byte write at offset 3
        request(1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
        awready = 1; wready = 1;
        run(1);
        data_req = 0;
        look();
        check("wb_wstrb", 32'(wstrb), 32'h8);
        check("wb_awsize", 32'(awsize), 32'd0);
        check("wb_wlast", 32'(wlast), 32'd1);
        adv();
        awready = 0; wready = 0;
        run(1);
        bvalid = 1;
        look();
        check("wb_data_ok", 32'(data_data_ok), 32'd1);
        adv();
        bvalid = 0;
        look();
        check("wb_data_ok_once", 32'(data_data_ok), 32'd0);
        adv();

        // W handshake before AW
        request(1, 2'd2, 32'h0000_0100, 32'h1234_5678);
        run(1);
        data_req = 0;
        wready = 1;
        run(1);
        wready = 0;
        look();
        check("wfirst_wvalid_low", 32'(wvalid), 32'd0);
        adv();
        look();
        check("wfirst_no_bready", 32'(bready), 32'd0);
        adv();
        awready = 1;
        run(1);
        awready = 0;
        look();
        check("wfirst_awvalid_low", 32'(awvalid), 32'd0);
        check("wfirst_bready", 32'(bready), 32'd1);
        adv();
        bvalid = 1;
        run(1);
        bvalid = 0;

        // Back-pressure on AR, second request held while busy
        request(0, 2'd1, 32'h2000_0012, 32'd0);
        run(1);
        for (int i = 0; i < 5; i++) begin
            look();
            check("bp_arvalid", 32'(arvalid), 32'd1);
            check("bp_araddr", araddr, 32'h2000_0012);
            check("bp_addr_ok", 32'(data_addr_ok), 32'd0);
            adv();
        end
        arready = 1;
        run(1);
        arready = 0;
        run(1);
        rvalid = 1; rdata = 32'h0000_5A5A;
        look();
        check("bp_data_ok", 32'(data_data_ok), 32'd1);
        check("bp_addr_ok_dok", 32'(data_addr_ok), 32'd0);
        adv();
        rvalid = 0;
        look();
        check("bp_addr_ok_after", 32'(data_addr_ok), 32'd1);
        adv();
        data_req = 0;
        arready = 1; rvalid = 1; rdata = 32'h0BAD_F00D;
        run(3);
        quiet();

        // Half writes at 0x10 and 0x12; error response still completes
        for (int k = 0; k < 2; k++) begin
            request(1, 2'd1, half_addr[k], 32'hC0DE_C0DE);
            awready = 1; wready = 1;
            run(1);
            data_req = 0;
            look();
            check("half_wstrb", 32'(wstrb), 32'(half_strb[k]));
            adv();
            bvalid = 1;
            look();
            check("half_data_ok", 32'(data_data_ok), 32'd1);
            adv();
            quiet();
        end

        // Asynchronous reset in the middle of RD_R
        request(0, 2'd2, 32'h0000_0040, 32'd0);
        arready = 1;
        run(1);
        data_req = 0;
        run(1);
        rvalid = 1; rdata = 32'h7777_7777;
        look();
        check("ar_rst_pre_rready", 32'(rready), 32'd1);
        #2;
        rst = 1;
        #1;
        model_reset();
        check("ar_rst_arvalid", 32'(arvalid), 32'd0);
        check("ar_rst_rready", 32'(rready), 32'd0);
        check("ar_rst_data_ok", 32'(data_data_ok), 32'd0);
        check("ar_rst_araddr", araddr, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        quiet();
        run(1);
        request(0, 2'd2, 32'h0000_0044, 32'd0);
        arready = 1;
        run(1);
        data_req = 0;
        run(1);
        rvalid = 1; rdata = 32'h1357_9BDF;
        look();
        check("post_rst_rdata", data_rdata, 32'h1357_9BDF);
        adv();
        quiet();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 3));
            data_addr  = $urandom;
            data_wdata = $urandom;
            arready    = 1'($urandom_range(0, 1));
            awready    = 1'($urandom_range(0, 1));
            wready     = 1'($urandom_range(0, 1));
            rvalid     = 1'($urandom_range(0, 1));
            bvalid     = 1'($urandom_range(0, 1));
            rdata      = $urandom;
            look();
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
